// File: rtl/jtframe_db15_reader.sv
// Purpose : serial reader for the DB15 dual-joystick adapter. It loads the
//           adapter, shifts in 32 bits per frame and accepts a frame only when
//           two identical frames arrive back to back.
// Latency : a held input reaches the outputs at the end of the second frame
//           that sees it. One frame is (65+GAP)*CLKDIV+1 clk.
// Backpressure: none. The adapter is free-running and the outputs are
//           level-held words plus a one-clk frame_done strobe.
// Ports   : clk/rst_n (sync, active-low); JOY_CLK/JOY_LOAD/JOY_DATA adapter
//           link; joystick1/joystick2 active-high words; present;
//           frame_done.
module jtframe_db15_reader #(
    parameter int CLKDIV = 24,
    parameter int GAP    = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    input  logic        JOY_DATA,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        present,
    output logic        frame_done
);
    localparam int DW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_GAP    = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    state_t          state;
    logic [DW-1:0]   div;
    logic            tick;
    logic [1:0]      sync;
    logic [4:0]      bitcnt;
    logic            phase;
    logic [GW-1:0]   gapcnt;
    logic [31:0]     shift;
    logic [31:0]     prev;

    assign tick = (div == DW'(CLKDIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_LOAD;
            div        <= '0;
            sync       <= 2'b11;
            bitcnt     <= '0;
            phase      <= 1'b0;
            gapcnt     <= '0;
            shift      <= '0;
            prev       <= '0;
            JOY_CLK    <= 1'b0;
            JOY_LOAD   <= 1'b1;
            joystick1  <= '0;
            joystick2  <= '0;
            present    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sync       <= {sync[0], JOY_DATA};
            frame_done <= 1'b0;
            div        <= tick ? '0 : div + 1'b1;

            case (state)
                ST_LOAD: begin
                    bitcnt  <= '0;
                    phase   <= 1'b0;
                    JOY_CLK <= 1'b0;
                    if (tick) begin
                        JOY_LOAD <= 1'b1;
                        state    <= ST_SHIFT;
                    end else begin
                        JOY_LOAD <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            // Sample before the rising edge so the adapter has
                            // had a full low half-period to settle the bit.
                            shift[bitcnt] <= ~sync[1];
                            JOY_CLK       <= 1'b1;
                            phase         <= 1'b1;
                        end else begin
                            JOY_CLK <= 1'b0;
                            phase   <= 1'b0;
                            bitcnt  <= bitcnt + 5'd1;
                            if (bitcnt == 5'd31) begin
                                state  <= ST_GAP;
                                gapcnt <= '0;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    JOY_CLK  <= 1'b0;
                    JOY_LOAD <= 1'b1;
                    if (tick) begin
                        if (gapcnt == GW'(GAP - 1)) begin
                            state <= ST_UPDATE;
                        end else begin
                            gapcnt <= gapcnt + 1'b1;
                        end
                    end
                end
                ST_UPDATE: begin
                    // Runs for one clk regardless of the tick; the divider
                    // restarts so the next LOAD lasts a full tick.
                    div      <= '0;
                    state    <= ST_LOAD;
                    JOY_LOAD <= 1'b0;
                    if (shift == 32'hFFFF_FFFF) begin
                        // Every button reads pressed: adapter absent or line stuck low.
                        joystick1 <= '0;
                        joystick2 <= '0;
                        present   <= 1'b0;
                    end else if (shift == prev) begin
                        joystick1  <= shift[15:0];
                        joystick2  <= shift[31:16];
                        present    <= 1'b1;
                        frame_done <= 1'b1;
                    end else begin
                        prev <= shift;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end
endmodule
